// File: rtl/fpu_phase_seq_pkg.sv
// Shared types and opcode constants for the FPU phase sequencer.
// The state encoding is visible on the phase output, so the values are fixed.
package fpu_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_IF       = 4'd1,
    ST_ID       = 4'd2,
    ST_ALU      = 4'd3,
    ST_MEM      = 4'd4,
    ST_MEM_WAIT = 4'd5,
    ST_RB       = 4'd6,
    ST_MFC_WAIT = 4'd7,
    ST_HALT     = 4'd8
  } seq_state_e;

  localparam logic [5:0] OP_HLT     = 6'b000000;
  localparam logic [5:0] OP_MFC     = 6'b111111;
  localparam logic [3:0] MEM_PREFIX = 4'b1110;

  // Memory instructions share a 4-bit major opcode prefix.
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op[5:2] == MEM_PREFIX);
  endfunction

endpackage

// File: rtl/fpu_phase_seq_if.sv
// Control/strobe bundle between the main CPU side and the phase sequencer.
// master = CPU/controller side, slave = sequencer.
interface fpu_phase_seq_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic             resume;
  logic [5:0]       opcode;
  logic             mfc_ack;
  logic             mem_ready;
  logic             IF_clk;
  logic             ID_clk;
  logic             ALU_clk;
  logic             MEM_clk;
  logic             RB_clk;
  logic [3:0]       phase;
  logic             busy;
  logic             halted;
  logic             mem_err;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output run, resume, opcode, mfc_ack, mem_ready,
    input  IF_clk, ID_clk, ALU_clk, MEM_clk, RB_clk,
    input  phase, busy, halted, mem_err, instr_count
  );

  modport slave (
    input  run, resume, opcode, mfc_ack, mem_ready,
    output IF_clk, ID_clk, ALU_clk, MEM_clk, RB_clk,
    output phase, busy, halted, mem_err, instr_count
  );
endinterface

// File: rtl/fpu_phase_seq.sv
// Phase sequencer: walks one instruction at a time through IF/ID/ALU/MEM/RB,
// with MFC and slow-memory stalls, a sticky memory-timeout error and HLT parking.
module fpu_phase_seq
  import fpu_seq_pkg::*;
#(
  parameter int ALU_LAT     = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  fpu_phase_seq_if.slave  bus
);

  localparam int ALU_CW = $clog2(ALU_LAT + 1);
  localparam int TO_CW  = $clog2(MEM_TIMEOUT + 1);
  localparam logic [ALU_CW-1:0] ALU_LAST = ALU_CW'(ALU_LAT);
  localparam logic [TO_CW-1:0]  TO_LAST  = TO_CW'(MEM_TIMEOUT - 1);

  seq_state_e        state_r;
  seq_state_e        next_state_s;
  logic              timeout_s;
  logic [ALU_CW-1:0] alu_cnt_r;
  logic [TO_CW-1:0]  to_cnt_r;
  logic [5:0]        op_q_r;
  logic [CNT_W-1:0]  instr_count_r;
  logic              if_clk_r;
  logic              id_clk_r;
  logic              alu_clk_r;
  logic              mem_clk_r;
  logic              rb_clk_r;
  logic              busy_r;
  logic              halted_r;
  logic              mem_err_r;

  // Next-state decode; the decision for each state uses only that state's inputs.
  always_comb begin
    next_state_s = state_r;
    timeout_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.run) next_state_s = ST_IF;
        else         next_state_s = ST_IDLE;
      end
      ST_IF: next_state_s = ST_ID;
      ST_ID: begin
        if (bus.opcode == OP_HLT)      next_state_s = ST_HALT;
        else if (bus.opcode == OP_MFC) next_state_s = ST_MFC_WAIT;
        else                           next_state_s = ST_ALU;
      end
      ST_ALU: begin
        if (alu_cnt_r == ALU_LAST) next_state_s = ST_MEM;
        else                       next_state_s = ST_ALU;
      end
      ST_MEM: begin
        if (is_mem_op(op_q_r)) next_state_s = ST_MEM_WAIT;
        else                   next_state_s = ST_RB;
      end
      ST_MEM_WAIT: begin
        if (bus.mem_ready) begin
          next_state_s = ST_RB;
        end else if (to_cnt_r == TO_LAST) begin
          next_state_s = ST_HALT;
          timeout_s    = 1'b1;
        end else begin
          next_state_s = ST_MEM_WAIT;
        end
      end
      ST_RB: begin
        if (bus.run) next_state_s = ST_IF;
        else         next_state_s = ST_IDLE;
      end
      ST_MFC_WAIT: begin
        if (bus.mfc_ack) next_state_s = ST_RB;
        else             next_state_s = ST_MFC_WAIT;
      end
      ST_HALT: begin
        if (bus.resume) next_state_s = ST_IDLE;
        else            next_state_s = ST_HALT;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, strobes, status and counters; strobes are decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      if_clk_r      <= 1'b0;
      id_clk_r      <= 1'b0;
      alu_clk_r     <= 1'b0;
      mem_clk_r     <= 1'b0;
      rb_clk_r      <= 1'b0;
      busy_r        <= 1'b0;
      halted_r      <= 1'b0;
      mem_err_r     <= 1'b0;
      op_q_r        <= 6'd0;
      alu_cnt_r     <= ALU_CW'(1);
      to_cnt_r      <= '0;
      instr_count_r <= '0;
    end else begin
      state_r   <= next_state_s;
      if_clk_r  <= (next_state_s == ST_IF);
      id_clk_r  <= (next_state_s == ST_ID);
      alu_clk_r <= (next_state_s == ST_ALU) && (state_r != ST_ALU);
      mem_clk_r <= (next_state_s == ST_MEM);
      rb_clk_r  <= (next_state_s == ST_RB);
      busy_r    <= !((next_state_s == ST_IDLE) || (next_state_s == ST_HALT));
      halted_r  <= (next_state_s == ST_HALT);
      if (timeout_s) mem_err_r <= 1'b1;
      if (state_r == ST_ID) op_q_r <= bus.opcode;
      // ALU counter sits at 1 so the first ALU cycle counts as cycle one.
      if (state_r != ST_ALU) alu_cnt_r <= ALU_CW'(1);
      else                   alu_cnt_r <= alu_cnt_r + ALU_CW'(1);
      if (state_r != ST_MEM_WAIT) to_cnt_r <= '0;
      else                        to_cnt_r <= to_cnt_r + TO_CW'(1);
      if (next_state_s == ST_RB) instr_count_r <= instr_count_r + CNT_W'(1);
    end
  end

  assign bus.IF_clk      = if_clk_r;
  assign bus.ID_clk      = id_clk_r;
  assign bus.ALU_clk     = alu_clk_r;
  assign bus.MEM_clk     = mem_clk_r;
  assign bus.RB_clk      = rb_clk_r;
  assign bus.phase       = state_r;
  assign bus.busy        = busy_r;
  assign bus.halted      = halted_r;
  assign bus.mem_err     = mem_err_r;
  assign bus.instr_count = instr_count_r;

endmodule

// File: tb/tb_fpu_phase_seq.sv
// Trace-driven bench: an instruction-level model expands each instruction into
// its expected per-cycle outputs plus inputs, then a single loop drives and compares.
module tb_fpu_phase_seq;
  import fpu_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a_n, rst_b_n;
  logic       run_d, resume_d, ack_d, rdy_d;
  logic [5:0] op_d;

  fpu_phase_seq_if #(.CNT_W(16)) if_a ();
  fpu_phase_seq_if #(.CNT_W(4))  if_b ();

  assign if_a.run = run_d;  assign if_a.resume = resume_d;  assign if_a.opcode = op_d;
  assign if_a.mfc_ack = ack_d;  assign if_a.mem_ready = rdy_d;
  assign if_b.run = run_d;  assign if_b.resume = resume_d;  assign if_b.opcode = op_d;
  assign if_b.mfc_ack = ack_d;  assign if_b.mem_ready = rdy_d;

  fpu_phase_seq #(.ALU_LAT(1), .MEM_TIMEOUT(16), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .bus(if_a));
  fpu_phase_seq #(.ALU_LAT(3), .MEM_TIMEOUT(5), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .bus(if_b));

  // One trace entry = one clock cycle: inputs driven in it, outputs expected in it.
  // ph: 0 idle,1 IF,2 ID,3 ALU,4 MEM,5 MEM_WAIT,6 RB,7 MFC_WAIT,8 HALT; stb: 0 none, 1..5 IF..RB
  typedef struct {
    bit          rst, run, res, ack, rdy;
    bit [5:0]    op;
    int          ph, stb;
    bit          err;
    int unsigned cnt;
  } cyc_t;

  cyc_t        tr[$];
  int unsigned m_cnt, cmask;
  bit          m_err;
  bit [5:0]    cur_op;
  int          alu_lat, mem_to;
  int          n_cmp = 0, n_fail = 0;

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(int ph, int stb, bit run, bit res, bit ack, bit rdy);
    cyc_t c;
    c.rst = 1'b0; c.run = run; c.res = res; c.ack = ack; c.rdy = rdy;
    c.op = cur_op; c.ph = ph; c.stb = stb; c.err = m_err; c.cnt = m_cnt;
    tr.push_back(c);
  endfunction

  function automatic void push_rst();
    m_cnt = 0; m_err = 1'b0; cur_op = 6'($urandom);
    push(0, 0, rb(), rb(), rb(), rb());
    tr[tr.size()-1].rst = 1'b1;
  endfunction

  function automatic void go_idle(int n);
    for (int i = 0; i < n; i++) begin
      cur_op = 6'($urandom);
      push(0, 0, 1'b0, rb(), rb(), rb());
    end
    cur_op = 6'($urandom);
    push(0, 0, 1'b1, rb(), rb(), rb());
  endfunction

  function automatic void halt_for(int n);
    for (int i = 0; i < n; i++) push(8, 0, rb(), (i == n - 1), rb(), rb());
  endfunction

  // Expands one instruction; returns 1 when the next instruction follows RB directly.
  function automatic bit gen_instr(bit [5:0] op, int ack_dly, int mem_dly, int halt_n,
                                   bit run_rb, bit rdy_in_mem);
    cur_op = 6'($urandom);
    push(1, 1, rb(), rb(), rb(), rb());
    cur_op = op;
    push(2, 2, rb(), rb(), rb(), rb());
    if (op == 6'b000000) begin
      halt_for(halt_n);
      return 1'b0;
    end
    if (op == 6'b111111) begin
      for (int i = 0; i < ack_dly; i++) push(7, 0, rb(), rb(), (i == ack_dly - 1), rb());
    end else begin
      for (int i = 0; i < alu_lat; i++) push(3, (i == 0) ? 3 : 0, rb(), rb(), rb(), rb());
      push(4, 4, rb(), rb(), rb(), rdy_in_mem);
      if (op[5:2] == 4'b1110) begin
        if (mem_dly > mem_to) begin
          for (int i = 0; i < mem_to; i++) push(5, 0, rb(), rb(), rb(), 1'b0);
          m_err = 1'b1;
          halt_for(halt_n);
          return 1'b0;
        end
        for (int i = 0; i < mem_dly; i++) push(5, 0, rb(), rb(), rb(), (i == mem_dly - 1));
      end
    end
    m_cnt = (m_cnt + 1) & cmask;
    push(6, 5, run_rb, rb(), rb(), rb());
    return run_rb;
  endfunction

  function automatic int find_ph(int from, int ph, bit second);
    for (int i = from; i < tr.size(); i++)
      if (tr[i].ph == ph && (!second || (i > 0 && tr[i-1].ph == ph))) return i;
    return -1;
  endfunction

  // Replace cycle j with an asynchronous reset and drop everything after it.
  function automatic void abort_at(int j);
    while (tr.size() > j + 1) void'(tr.pop_back());
    m_cnt = 0; m_err = 1'b0;
    tr[j].rst = 1'b1; tr[j].ph = 0; tr[j].stb = 0; tr[j].err = 1'b0; tr[j].cnt = 0;
  endfunction

  function automatic void random_instrs(int n, bit allow_abort);
    bit nxt;
    int s, j, r;
    bit [5:0] op;
    for (int k = 0; k < n; k++) begin
      s = tr.size();
      r = int'($urandom_range(0, 9));
      if (r == 0)      op = 6'b000000;
      else if (r <= 2) op = 6'b111111;
      else if (r <= 5) op = {4'b1110, 2'($urandom)};
      else             op = 6'($urandom);
      nxt = gen_instr(op, int'($urandom_range(1, 4)), int'($urandom_range(1, mem_to + 2)),
                      int'($urandom_range(1, 3)), rb(), rb());
      j = -1;
      if (allow_abort && $urandom_range(0, 7) == 0)
        j = find_ph(s + 1, int'($urandom_range(1, 8)), 1'b0);
      if (j >= 0) begin
        abort_at(j);
        go_idle(int'($urandom_range(0, 2)));
      end else if (!nxt) begin
        go_idle(int'($urandom_range(0, 2)));
      end
    end
  endfunction

  task automatic check(string name, int got, int expv);
    n_cmp++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  task automatic cmp_cycle(int k, bit use_b);
    logic [27:0] e, g;
    logic [4:0]  es;
    cyc_t        c;
    c  = tr[k];
    es = (c.stb == 0) ? 5'd0 : 5'(5'd1 << (c.stb - 1));
    e  = {es, 4'(c.ph), (c.ph != 0 && c.ph != 8), (c.ph == 8), c.err, 16'(c.cnt)};
    if (use_b)
      g = {if_b.RB_clk, if_b.MEM_clk, if_b.ALU_clk, if_b.ID_clk, if_b.IF_clk, if_b.phase,
           if_b.busy, if_b.halted, if_b.mem_err, 16'(if_b.instr_count)};
    else
      g = {if_a.RB_clk, if_a.MEM_clk, if_a.ALU_clk, if_a.ID_clk, if_a.IF_clk, if_a.phase,
           if_a.busy, if_a.halted, if_a.mem_err, 16'(if_a.instr_count)};
    n_cmp++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL cycle %0d dut_%s {stb,phase,busy,halted,err,cnt}: got %h, expected %h",
               k, use_b ? "b" : "a", g, e);
    end
  endtask

  task automatic run_trace(bit use_b);
    for (int k = 0; k < tr.size(); k++) begin
      @(posedge clk);
      #1;
      run_d = tr[k].run; resume_d = tr[k].res; ack_d = tr[k].ack;
      rdy_d = tr[k].rdy; op_d = tr[k].op;
      if (use_b) rst_b_n = !tr[k].rst;
      else       rst_a_n = !tr[k].rst;
      @(negedge clk);
      cmp_cycle(k, use_b);
    end
  endtask

  initial begin
    int s, s2, s3, j, nwait;
    bit nxt;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    run_d = 1'b0; resume_d = 1'b0; ack_d = 1'b0; rdy_d = 1'b0; op_d = 6'd0;

    // ---- DUT A: ALU_LAT=1, MEM_TIMEOUT=16, 16-bit counter
    alu_lat = 1; mem_to = 16; cmask = 32'h0000_FFFF;
    tr.delete();
    push_rst(); push_rst();
    s = tr.size();
    go_idle(0);
    nxt = gen_instr(6'b100001, 1, 1, 1, 1'b1, 1'b0);
    check("plain IF at cycle 1", tr[s+1].stb, 1);
    check("plain ID at cycle 2", tr[s+2].stb, 2);
    check("plain ALU at cycle 3", tr[s+3].stb, 3);
    check("plain MEM at cycle 4", tr[s+4].stb, 4);
    check("plain RB at cycle 5", tr[s+5].stb, 5);
    check("count after first RB", int'(tr[s+5].cnt), 1);
    s2 = tr.size();
    nxt = gen_instr(6'b111000, 1, 3, 1, 1'b1, 1'b1);
    check("IF right after RB", tr[s2].stb, 1);
    check("mem op MEM at cycle 4", tr[s2+3].stb, 4);
    check("mem op wait cycle 7", tr[s2+6].ph, 5);
    check("mem op RB at cycle 8", tr[s2+7].stb, 5);
    nxt = gen_instr(6'b111111, 3, 1, 1, 1'b1, 1'b0);
    s3 = tr.size();
    nxt = gen_instr(6'b000000, 1, 1, 3, 1'b1, 1'b0);
    check("HLT leaves count", int'(tr[s3+2].cnt), 3);
    go_idle(0);
    s3 = tr.size();
    nxt = gen_instr(6'b111001, 1, 99, 2, 1'b1, 1'b0);
    nwait = 0;
    for (int i = s3; i < tr.size(); i++) if (tr[i].ph == 5) nwait++;
    check("timeout wait cycles", nwait, 16);
    check("timeout sets err in HALT", int'(tr[s3+20].err), 1);
    go_idle(1);
    random_instrs(300, 1'b1);
    run_trace(1'b0);
    @(posedge clk); #1; rst_a_n = 1'b0;

    // ---- DUT B: ALU_LAT=3, MEM_TIMEOUT=5, 4-bit counter
    alu_lat = 3; mem_to = 5; cmask = 32'h0000_000F;
    tr.delete();
    push_rst(); push_rst();
    go_idle(0);
    for (int i = 0; i < 16; i++) nxt = gen_instr(6'b100001, 1, 1, 1, 1'b1, rb());
    check("count wraps to 0", int'(m_cnt), 0);
    s = tr.size();
    nxt = gen_instr(6'b000101, 1, 1, 1, 1'b1, 1'b0);
    j = find_ph(s + 1, 3, 1'b1);
    check("second ALU cycle offset", j - s, 3);
    if (j >= 0) abort_at(j);
    go_idle(1);
    s = tr.size();
    nxt = gen_instr(6'b111010, 1, 4, 1, 1'b1, 1'b0);
    j = find_ph(s + 1, 5, 1'b1);
    check("second MEM_WAIT offset", j - s, 7);
    if (j >= 0) abort_at(j);
    go_idle(0);
    random_instrs(300, 1'b1);
    run_trace(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
